// File: rtl/cnt_pkg.sv
// Shared types and encodings for the counter-chain controller.
package cnt_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cnt_state_t;

  localparam logic CIN_ACTIVE = 1'b0;
  localparam logic CON_TERM   = 1'b0;
  localparam int   WRAPS_W    = 8;
endpackage

// File: rtl/cnt_prescale.sv
// Prescale divider: tick is a flop that is high for the cycle in which the count equals pre.
module cnt_prescale #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);
  logic [PRE_W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (!clr && cnt != pre) cnt_nxt = cnt + 1'b1;
  end

  // en is the next-cycle run flag, so tick lines up with the cycle it describes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= en && (cnt_nxt == pre);
    end
  end
endmodule

// File: rtl/cnt_chain_ctrl.sv
// Command-driven controller for a cascadable up/down counter: load, paced count strobes,
// terminal detection on the active-low carry-out, then done or auto-reload.
module cnt_chain_ctrl
  import cnt_pkg::*;
#(
  parameter int W     = 8,
  parameter int PRE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [W-1:0]       cmd_load,
  input  logic               cmd_up,
  input  logic [PRE_W-1:0]   cmd_pre,
  input  logic               cmd_reload,
  input  logic               abort,
  input  logic               con,
  output logic               pl,
  output logic [W-1:0]       din,
  output logic               encnt,
  output logic               inc,
  output logic               dec,
  output logic               cin,
  output logic               busy,
  output logic               done,
  output logic [WRAPS_W-1:0] wraps
);
  cnt_state_t       state, state_nxt;
  logic [PRE_W-1:0] pre_r;
  logic             reload_r;
  logic             tick, accept, terminal;

  assign accept   = cmd_valid && cmd_ready;
  assign terminal = (state == RUN) && tick && (con == CON_TERM);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = abort ? IDLE : RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (terminal) state_nxt = reload_r ? LOAD : DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  cnt_prescale #(.PRE_W(PRE_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (state != RUN),
    .en    (state_nxt == RUN),
    .pre   (pre_r),
    .tick  (tick)
  );

  assign cin = tick ? CIN_ACTIVE : ~CIN_ACTIVE;

  // Outputs are registered from the next state so they coincide with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      pl        <= 1'b0;
      encnt     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      din       <= '0;
      inc       <= 1'b1;
      dec       <= 1'b0;
      pre_r     <= '0;
      reload_r  <= 1'b0;
      wraps     <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      pl        <= (state_nxt == LOAD);
      encnt     <= (state_nxt == LOAD) || (state_nxt == RUN);
      busy      <= (state_nxt == LOAD) || (state_nxt == RUN);
      done      <= (state_nxt == DONE);
      if (accept) begin
        din      <= cmd_load;
        inc      <= cmd_up;
        dec      <= ~cmd_up;
        pre_r    <= cmd_pre;
        reload_r <= cmd_reload;
        wraps    <= '0;
      end else if (terminal && reload_r && !abort && wraps != '1) begin
        wraps <= wraps + 1'b1;
      end
    end
  end
endmodule
